// File: rtl/calculo_preco_if.sv
// Bundle of the product/weight inputs and price outputs of calculo_preco.
// The master side (filtragem_peso / bench) drives product and weight;
// the slave side (calculo_preco) drives price, valid and busy flags.
interface calculo_preco_if;
    logic [1:0]  produto;
    logic [10:0] peso_liq;
    logic [15:0] preco_total;
    logic        valido;
    logic        ocupado;

    modport master (
        output produto,
        output peso_liq,
        input  preco_total,
        input  valido,
        input  ocupado
    );

    modport slave (
        input  produto,
        input  peso_liq,
        output preco_total,
        output valido,
        output ocupado
    );
endinterface

// File: rtl/calculo_preco.sv
// Price computation stage of the supermarket scale.
// Waits for product/weight to stay unchanged for ESTAB_CICLOS edges, then
// computes round((peso * preco_kg) / 1000) with an 11-step shift-add
// multiply followed by a 25-step restoring divide by 1000. Any input change
// during the computation aborts it; a change after completion clears the result.
module calculo_preco #(
    parameter int unsigned PRECO_BANANA    = 299,
    parameter int unsigned PRECO_MARACUJA  = 899,
    parameter int unsigned PRECO_TANGERINA = 450,
    parameter int unsigned ESTAB_CICLOS    = 8
) (
    input  logic          clk,
    input  logic          rst,
    calculo_preco_if.slave bus
);
    localparam int unsigned CONT_W = $clog2(ESTAB_CICLOS) + 1;

    typedef enum logic [1:0] {
        ESPERA,
        MULT,
        DIV,
        PRONTO
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [CONT_W-1:0] cont_q, cont_d;
    logic [10:0]       peso_cap_q, peso_cap_d;
    logic [1:0]        prod_cap_q, prod_cap_d;
    logic [24:0]       mcand_q, mcand_d;
    logic [10:0]       mplier_q, mplier_d;
    logic [24:0]       acc_q, acc_d;
    logic [9:0]        rem_q, rem_d;
    logic [4:0]        passo_q, passo_d;
    logic [15:0]       preco_q, preco_d;
    logic              valido_q, valido_d;
    logic              ocupado_q, ocupado_d;

    logic              iguais;
    logic [13:0]       preco_sel;
    logic [24:0]       soma;
    logic [10:0]       rem_sh;
    logic              q_bit;
    logic [9:0]        rem_novo;
    logic [24:0]       quoc_prox;

    // Inputs compared against the values captured at the previous edge.
    always_comb begin
        iguais = (bus.produto == prod_cap_q) && (bus.peso_liq == peso_cap_q);
    end

    // Per-kg price of the captured product.
    always_comb begin
        case (prod_cap_q)
            2'b01:   preco_sel = PRECO_BANANA[13:0];
            2'b10:   preco_sel = PRECO_MARACUJA[13:0];
            2'b11:   preco_sel = PRECO_TANGERINA[13:0];
            default: preco_sel = '0;
        endcase
    end

    // One multiply step and one restoring-divide step; acc_q holds the product,
    // then the dividend whose bits are shifted out while quotient bits shift in.
    always_comb begin
        soma      = acc_q + (mplier_q[0] ? mcand_q : '0);
        rem_sh    = {rem_q, acc_q[24]};
        q_bit     = (rem_sh >= 11'd1000);
        rem_novo  = q_bit ? 10'(rem_sh - 11'd1000) : rem_sh[9:0];
        quoc_prox = {acc_q[23:0], q_bit};
    end

    // Next-state and output logic of the wait/multiply/divide/ready sequencer.
    always_comb begin
        estado_d   = estado_q;
        cont_d     = cont_q;
        peso_cap_d = peso_cap_q;
        prod_cap_d = prod_cap_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        passo_d    = passo_q;
        preco_d    = preco_q;
        valido_d   = valido_q;

        case (estado_q)
            ESPERA: begin
                peso_cap_d = bus.peso_liq;
                prod_cap_d = bus.produto;
                preco_d    = '0;
                valido_d   = 1'b0;
                if (iguais && (bus.produto != 2'b00)) begin
                    // cont counts equal edges after the capture edge, so the
                    // ESTAB_CICLOS-th edge sees cont == ESTAB_CICLOS-2.
                    if (cont_q == CONT_W'(ESTAB_CICLOS - 2)) begin
                        estado_d = MULT;
                        cont_d   = '0;
                        mcand_d  = {11'b0, preco_sel};
                        mplier_d = peso_cap_q;
                        acc_d    = '0;
                        passo_d  = '0;
                    end else begin
                        cont_d = cont_q + 1'b1;
                    end
                end else begin
                    cont_d = '0;
                end
            end

            MULT: begin
                if (!iguais) begin
                    estado_d   = ESPERA;
                    cont_d     = '0;
                    peso_cap_d = bus.peso_liq;
                    prod_cap_d = bus.produto;
                    preco_d    = '0;
                    valido_d   = 1'b0;
                end else begin
                    acc_d    = soma;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    passo_d  = passo_q + 5'd1;
                    if (passo_q == 5'd10) begin
                        acc_d    = soma + 25'd500;
                        rem_d    = '0;
                        passo_d  = '0;
                        estado_d = DIV;
                    end
                end
            end

            DIV: begin
                if (!iguais) begin
                    estado_d   = ESPERA;
                    cont_d     = '0;
                    peso_cap_d = bus.peso_liq;
                    prod_cap_d = bus.produto;
                    preco_d    = '0;
                    valido_d   = 1'b0;
                end else begin
                    rem_d   = rem_novo;
                    acc_d   = quoc_prox;
                    passo_d = passo_q + 5'd1;
                    if (passo_q == 5'd24) begin
                        preco_d  = quoc_prox[15:0];
                        valido_d = 1'b1;
                        estado_d = PRONTO;
                    end
                end
            end

            PRONTO: begin
                if (!iguais) begin
                    estado_d   = ESPERA;
                    cont_d     = '0;
                    peso_cap_d = bus.peso_liq;
                    prod_cap_d = bus.produto;
                    preco_d    = '0;
                    valido_d   = 1'b0;
                end
            end

            default: begin
                estado_d = ESPERA;
                cont_d   = '0;
                preco_d  = '0;
                valido_d = 1'b0;
            end
        endcase

        ocupado_d = (estado_d == MULT) || (estado_d == DIV);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= ESPERA;
            cont_q     <= '0;
            peso_cap_q <= '0;
            prod_cap_q <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            passo_q    <= '0;
            preco_q    <= '0;
            valido_q   <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cont_q     <= cont_d;
            peso_cap_q <= peso_cap_d;
            prod_cap_q <= prod_cap_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            passo_q    <= passo_d;
            preco_q    <= preco_d;
            valido_q   <= valido_d;
            ocupado_q  <= ocupado_d;
        end
    end

    assign bus.preco_total = preco_q;
    assign bus.valido      = valido_q;
    assign bus.ocupado     = ocupado_q;
endmodule

// File: tb/tb_calculo_preco.sv
// Testbench for calculo_preco: price = round-half-up(peso * preco_kg / 1000),
// result valid ESTAB_CICLOS+36 edges after the inputs change.
module tb_calculo_preco;
    localparam int ESTAB   = 8;
    localparam int LAT     = ESTAB + 36;
    localparam int BUSY_N  = 36;
    localparam int MAXWAIT = 80;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    calculo_preco_if bus_a ();
    calculo_preco_if bus_b ();

    calculo_preco dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    calculo_preco #(.PRECO_BANANA(16383)) dut_max (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Reference: per-kg price table and rounded total in cents.
    function automatic int ref_price(input int prod, input int peso, input int banana);
        int kg;
        case (prod)
            1:       kg = banana;
            2:       kg = 899;
            3:       kg = 450;
            default: kg = 0;
        endcase
        return (peso * kg + 500) / 1000;
    endfunction

    // Steps edges until valido is seen, recording latency and busy profile.
    task automatic measure(input bit use_b, input int max_edges, output int lat,
                           output int busy_n, output int busy_first, output int price);
        logic v, o;
        logic [15:0] p;
        lat = -1; busy_n = 0; busy_first = -1; price = -1;
        for (int n = 1; n <= max_edges; n++) begin
            @(posedge clk); #1;
            v = use_b ? bus_b.valido      : bus_a.valido;
            o = use_b ? bus_b.ocupado     : bus_a.ocupado;
            p = use_b ? bus_b.preco_total : bus_a.preco_total;
            if (o) begin
                busy_n++;
                if (busy_first < 0) busy_first = n;
            end
            if (v) begin
                lat = n;
                price = int'(p);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.produto = 2'b00; bus_a.peso_liq = '0;
        bus_b.produto = 2'b00; bus_b.peso_liq = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus_a.preco_total !== 16'd0) begin bad++; $display("FAIL reset_preco: got %0d expected 0", bus_a.preco_total); end
        total++; if (bus_a.valido !== 1'b0) begin bad++; $display("FAIL reset_valido: got %b expected 0", bus_a.valido); end
        total++; if (bus_a.ocupado !== 1'b0) begin bad++; $display("FAIL reset_ocupado: got %b expected 0", bus_a.ocupado); end
        total++; if (bus_b.valido !== 1'b0) begin bad++; $display("FAIL reset_valido_b: got %b expected 0", bus_b.valido); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int prods [6] = '{1, 2, 3, 1, 1, 1};
        int pesos [6] = '{1000, 1500, 940, 1, 2, 0};
        int lat, bn, bf, pr, exp_p;
        for (int i = 0; i < 6; i++) begin
            bus_a.produto  = 2'(prods[i]);
            bus_a.peso_liq = 11'(pesos[i]);
            exp_p = ref_price(prods[i], pesos[i], 299);
            measure(1'b0, MAXWAIT, lat, bn, bf, pr);
            total++; if (lat != LAT) begin bad++; $display("FAIL basic%0d_latency: got %0d expected %0d", i, lat, LAT); end
            total++; if (pr != exp_p) begin bad++; $display("FAIL basic%0d_price: got %0d expected %0d", i, pr, exp_p); end
            total++; if (bn != BUSY_N) begin bad++; $display("FAIL basic%0d_busy_edges: got %0d expected %0d", i, bn, BUSY_N); end
            total++; if (bf != ESTAB) begin bad++; $display("FAIL basic%0d_busy_start: got %0d expected %0d", i, bf, ESTAB); end
        end
    endtask

    task automatic test_override_max();
        int lat, bn, bf, pr, exp_p;
        bus_b.produto  = 2'b01;
        bus_b.peso_liq = 11'd2047;
        exp_p = ref_price(1, 2047, 16383);
        measure(1'b1, MAXWAIT, lat, bn, bf, pr);
        total++; if (lat != LAT) begin bad++; $display("FAIL max_latency: got %0d expected %0d", lat, LAT); end
        total++; if (pr != exp_p) begin bad++; $display("FAIL max_price: got %0d expected %0d", pr, exp_p); end
    endtask

    task automatic test_abort_div();
        int lat, bn, bf, pr, early, exp_p;
        early = 0;
        bus_a.produto  = 2'b01;
        bus_a.peso_liq = 11'd1000;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk); #1;
            if (bus_a.valido) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL abort_pre_valido: got %0d expected 0", early); end
        total++; if (bus_a.ocupado !== 1'b1) begin bad++; $display("FAIL abort_in_div: got %b expected 1", bus_a.ocupado); end
        bus_a.peso_liq = 11'd1200;
        exp_p = ref_price(1, 1200, 299);
        measure(1'b0, MAXWAIT, lat, bn, bf, pr);
        total++; if (bf != ESTAB) begin bad++; $display("FAIL abort_busy_restart: got %0d expected %0d", bf, ESTAB); end
        total++; if (lat != LAT) begin bad++; $display("FAIL abort_latency: got %0d expected %0d", lat, LAT); end
        total++; if (pr != exp_p) begin bad++; $display("FAIL abort_price: got %0d expected %0d", pr, exp_p); end
    endtask

    task automatic test_pronto_clear();
        int act;
        act = 0;
        bus_a.produto = 2'b00;
        @(posedge clk); #1;
        total++; if (bus_a.valido !== 1'b0) begin bad++; $display("FAIL clear_valido: got %b expected 0", bus_a.valido); end
        total++; if (bus_a.preco_total !== 16'd0) begin bad++; $display("FAIL clear_preco: got %0d expected 0", bus_a.preco_total); end
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (bus_a.valido || bus_a.ocupado) act++;
        end
        total++; if (act != 0) begin bad++; $display("FAIL none_stays_idle: got %0d active edges expected 0", act); end
    endtask

    task automatic test_unstable();
        int act, peso, prod, lat, bn, bf, pr, exp_p;
        act = 0;
        peso = int'(bus_a.peso_liq);
        prod = 1;
        for (int k = 0; k < 12; k++) begin
            prod = int'($urandom_range(1, 3));
            peso = (peso + 1 + int'($urandom_range(0, 500))) % 2048;
            bus_a.produto  = 2'(prod);
            bus_a.peso_liq = 11'(peso);
            for (int n = 0; n < 5; n++) begin
                @(posedge clk); #1;
                if (bus_a.ocupado || bus_a.valido) act++;
            end
        end
        total++; if (act != 0) begin bad++; $display("FAIL unstable_no_mult: got %0d active edges expected 0", act); end
        peso = (peso + 7) % 2048;
        bus_a.peso_liq = 11'(peso);
        exp_p = ref_price(prod, peso, 299);
        measure(1'b0, MAXWAIT, lat, bn, bf, pr);
        total++; if (lat != LAT) begin bad++; $display("FAIL settle_latency: got %0d expected %0d", lat, LAT); end
        total++; if (pr != exp_p) begin bad++; $display("FAIL settle_price: got %0d expected %0d", pr, exp_p); end
    endtask

    task automatic test_reset_mid();
        int lat, bn, bf, pr, exp_p;
        bus_a.produto  = 2'b10;
        bus_a.peso_liq = 11'd1500;
        exp_p = ref_price(2, 1500, 299);
        repeat (12) @(posedge clk);
        #1;
        total++; if (bus_a.ocupado !== 1'b1) begin bad++; $display("FAIL midmult_busy: got %b expected 1", bus_a.ocupado); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus_a.ocupado !== 1'b0) begin bad++; $display("FAIL rst_async_ocupado: got %b expected 0", bus_a.ocupado); end
        total++; if (bus_a.valido !== 1'b0) begin bad++; $display("FAIL rst_async_valido: got %b expected 0", bus_a.valido); end
        @(posedge clk); #1;
        rst = 1'b0;
        measure(1'b0, MAXWAIT, lat, bn, bf, pr);
        total++; if (lat != LAT) begin bad++; $display("FAIL rst_rerun_latency: got %0d expected %0d", lat, LAT); end
        total++; if (pr != exp_p) begin bad++; $display("FAIL rst_rerun_price: got %0d expected %0d", pr, exp_p); end
        // Reset while a nonzero result is held must clear it without a clock edge.
        #3 rst = 1'b1;
        #1;
        total++; if (bus_a.preco_total !== 16'd0) begin bad++; $display("FAIL rst_pronto_preco: got %0d expected 0", bus_a.preco_total); end
        total++; if (bus_a.valido !== 1'b0) begin bad++; $display("FAIL rst_pronto_valido: got %b expected 0", bus_a.valido); end
        total++; if (bus_b.preco_total !== 16'd0) begin bad++; $display("FAIL rst_pronto_preco_b: got %0d expected 0", bus_b.preco_total); end
        @(posedge clk); #1;
        rst = 1'b0;
        measure(1'b0, MAXWAIT, lat, bn, bf, pr);
        total++; if (lat != LAT) begin bad++; $display("FAIL rst2_latency: got %0d expected %0d", lat, LAT); end
        total++; if (pr != exp_p) begin bad++; $display("FAIL rst2_price: got %0d expected %0d", pr, exp_p); end
    endtask

    task automatic test_back_to_back_random();
        int prod, peso, lat, bn, bf, pr, exp_p;
        for (int i = 0; i < 8; i++) begin
            prod = int'($urandom_range(1, 3));
            peso = int'($urandom_range(0, 2047));
            if (prod == int'(bus_a.produto) && peso == int'(bus_a.peso_liq)) peso = peso ^ 1;
            bus_a.produto  = 2'(prod);
            bus_a.peso_liq = 11'(peso);
            exp_p = ref_price(prod, peso, 299);
            measure(1'b0, MAXWAIT, lat, bn, bf, pr);
            total++; if (lat != LAT) begin bad++; $display("FAIL rand%0d_latency: got %0d expected %0d (prod=%0d peso=%0d)", i, lat, LAT, prod, peso); end
            total++; if (pr != exp_p) begin bad++; $display("FAIL rand%0d_price: got %0d expected %0d (prod=%0d peso=%0d)", i, pr, exp_p, prod, peso); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_override_max();
        test_abort_div();
        test_pronto_clear();
        test_unstable();
        test_reset_mid();
        test_back_to_back_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
